// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, coordinate type and sync-bit layout for the
// 640x480@60 pixel timing generator and the mappers that consume it.
package vga_timing_pkg;

  // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical).
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Sync pulses occupy [START, END) of the respective counter.
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Scan coordinates are 10 bits, so totals above 1024 cannot be represented.
  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // Bit layout carried through the sync delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_bits_t;

  // Idle value: both syncs inactive (high), nothing visible.
  localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  // True when lo <= v < hi; compared as int so hi may equal COORD_MAX.
  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Scan-position / sync bundle driven by the timing generator and read by
// the background and sprite mappers and the DAC/HDMI encoder.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t      DrawX;
  coord_t      DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        hs_d;
  logic        vs_d;
  logic        blank_d;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    input  DrawX, DrawY, blank, hs, vs, hs_d, vs_d, blank_d,
           line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register with synchronous reset to RST_VAL.
// DEPTH=0 degenerates to a wire so downstream taps need no special case.
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    // Clock and reset are intentionally unused when there is no storage.
    logic unused_clk_rst;
    assign unused_clk_rst = vga_clk ^ reset;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per pixel; reset flushes every stage to the idle value.
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage[i] <= RST_VAL;
        end
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel timing generator. Counters park on the last pixel
// of the frame during reset so the first released cycle is (0,0). All
// decodes are taken from the next-count values and registered, so they are
// aligned with DrawX/DrawY with no extra latency.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIPE_DLY = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vid
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > COORD_MAX) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > COORD_MAX) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if ((PIPE_DLY < 0) || (PIPE_DLY > 7)) begin : g_dly_chk
    $error("vga_timing_gen: PIPE_DLY must be 0..7");
  end

  coord_t      x_cnt;
  coord_t      y_cnt;
  logic        blank_reg;
  logic        hs_reg;
  logic        vs_reg;
  logic        line_start_reg;
  logic        frame_start_reg;
  logic [15:0] frame_count;

  coord_t      next_x;
  coord_t      next_y;
  logic        next_blank;
  logic        next_hs;
  logic        next_vs;
  logic        next_line_start;
  logic        next_frame_start;

  sync_bits_t  sync_now;
  sync_bits_t  sync_late;

  // Next scan position: X wraps every line, Y advances and wraps on X wrap.
  always_comb begin
    next_x = x_cnt;
    next_y = y_cnt;
    if (x_cnt == H_LAST) begin
      next_x = '0;
      if (y_cnt == V_LAST) begin
        next_y = '0;
      end else begin
        next_y = y_cnt + 10'd1;
      end
    end else begin
      next_x = x_cnt + 10'd1;
      next_y = y_cnt;
    end
  end

  // Decode visibility, syncs and strobes for the position about to be loaded.
  always_comb begin
    next_blank       = in_window(next_x, 0, H_ACTIVE) && in_window(next_y, 0, V_ACTIVE);
    next_hs          = !in_window(next_x, H_SYNC_START, H_SYNC_END);
    next_vs          = !in_window(next_y, V_SYNC_START, V_SYNC_END);
    next_line_start  = (next_x == 10'd0);
    next_frame_start = (next_x == 10'd0) && (next_y == 10'd0);
  end

  // Scan counters, registered decodes and the frame counter.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_cnt           <= H_LAST;
      y_cnt           <= V_LAST;
      blank_reg       <= 1'b0;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count     <= 16'd0;
    end else begin
      x_cnt           <= next_x;
      y_cnt           <= next_y;
      blank_reg       <= next_blank;
      hs_reg          <= next_hs;
      vs_reg          <= next_vs;
      line_start_reg  <= next_line_start;
      frame_start_reg <= next_frame_start;
      if (next_frame_start) begin
        frame_count <= frame_count + 16'd1;
      end else begin
        frame_count <= frame_count;
      end
    end
  end

  assign sync_now = '{hs: hs_reg, vs: vs_reg, blank: blank_reg};

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     (sync_now),
    .dout    (sync_late)
  );

  assign vid.DrawX       = x_cnt;
  assign vid.DrawY       = y_cnt;
  assign vid.blank       = blank_reg;
  assign vid.hs          = hs_reg;
  assign vid.vs          = vs_reg;
  assign vid.line_start  = line_start_reg;
  assign vid.frame_start = frame_start_reg;
  assign vid.frame_cnt   = frame_count;
  assign vid.hs_d        = sync_late.hs;
  assign vid.vs_d        = sync_late.vs;
  assign vid.blank_d     = sync_late.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: one default-timing DUT for reset/line checks and two
// shrunken-timing DUTs (PIPE_DLY=2 and 0) so frame-level behaviour fits in
// a few thousand cycles. A bench-side model pushes the expected outputs of
// every DUT at each clock edge; they are popped and compared on the falling edge.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int HA[3] = '{640, 8, 5};
  int HF[3] = '{16, 2, 1};
  int HS[3] = '{96, 3, 2};
  int HB[3] = '{48, 2, 3};
  int VA[3] = '{480, 6, 4};
  int VF[3] = '{10, 1, 2};
  int VS[3] = '{2, 2, 1};
  int VB[3] = '{33, 1, 1};
  int PD[3] = '{2, 2, 0};

  int          mx [3];
  int          my [3];
  logic [15:0] mfc [3];
  logic [2:0]  hist [3][8];
  logic [43:0] sb [$];

  vga_timing_gen_if vif0 ();
  vga_timing_gen_if vif1 ();
  vga_timing_gen_if vif2 ();

  vga_timing_gen dut0 (.vga_clk(clk), .reset(rst), .vid(vif0));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(2)
  ) dut1 (.vga_clk(clk), .reset(rst), .vid(vif1));

  vga_timing_gen #(
    .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(1), .PIPE_DLY(0)
  ) dut2 (.vga_clk(clk), .reset(rst), .vid(vif2));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic finish_up();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [43:0] obs(input int k);
    case (k)
      0: return {vif0.DrawX, vif0.DrawY, vif0.blank, vif0.hs, vif0.vs, vif0.line_start,
                 vif0.frame_start, vif0.frame_cnt, vif0.hs_d, vif0.vs_d, vif0.blank_d};
      1: return {vif1.DrawX, vif1.DrawY, vif1.blank, vif1.hs, vif1.vs, vif1.line_start,
                 vif1.frame_start, vif1.frame_cnt, vif1.hs_d, vif1.vs_d, vif1.blank_d};
      2: return {vif2.DrawX, vif2.DrawY, vif2.blank, vif2.hs, vif2.vs, vif2.line_start,
                 vif2.frame_start, vif2.frame_cnt, vif2.hs_d, vif2.vs_d, vif2.blank_d};
      default: return 44'd0;
    endcase
  endfunction

  // Reference behaviour of every DUT for one clock edge with reset value r.
  task automatic model_edge(input logic r);
    for (int k = 0; k < 3; k++) begin
      int ht;
      int vt;
      logic bl, hsv, vsv, ls, fs;
      logic [2:0] hd;
      ht = HA[k] + HF[k] + HS[k] + HB[k];
      vt = VA[k] + VF[k] + VS[k] + VB[k];
      if (r) begin
        mx[k] = ht - 1;
        my[k] = vt - 1;
        mfc[k] = 16'd0;
        bl = 1'b0; hsv = 1'b1; vsv = 1'b1; ls = 1'b0; fs = 1'b0;
        for (int i = 0; i < 8; i++) hist[k][i] = 3'b110;
      end else begin
        if (mx[k] == ht - 1) begin
          mx[k] = 0;
          my[k] = (my[k] == vt - 1) ? 0 : my[k] + 1;
        end else begin
          mx[k] = mx[k] + 1;
        end
        bl  = (mx[k] < HA[k]) && (my[k] < VA[k]);
        hsv = !((mx[k] >= HA[k] + HF[k]) && (mx[k] < HA[k] + HF[k] + HS[k]));
        vsv = !((my[k] >= VA[k] + VF[k]) && (my[k] < VA[k] + VF[k] + VS[k]));
        ls  = (mx[k] == 0);
        fs  = ls && (my[k] == 0);
        if (fs) mfc[k] = mfc[k] + 16'd1;
        for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = {hsv, vsv, bl};
      end
      hd = hist[k][PD[k]];
      sb.push_back({10'(mx[k]), 10'(my[k]), bl, hsv, vsv, ls, fs, mfc[k], hd});
    end
  endtask

  // One clock: drive reset, model the edge, compare all DUTs on the falling edge.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("sb_dut%0d", k), 64'(obs(k)), 64'(sb.pop_front()));
    end
    if (failures > 40) finish_up();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, bl_hi, ls_cnt, fall_x, hs_first, vs_low, fs_prev, fs_period, found;
    @(negedge clk);

    // Reset held 5 cycles, then release.
    repeat (5) step(1'b1);
    check_eq("rst_x", 64'(vif0.DrawX), 64'd799);
    check_eq("rst_y", 64'(vif0.DrawY), 64'd524);
    check_eq("rst_blank", 64'(vif0.blank), 64'd0);
    check_eq("rst_hs", 64'(vif0.hs), 64'd1);
    check_eq("rst_vs", 64'(vif0.vs), 64'd1);
    check_eq("rst_fc", 64'(vif0.frame_cnt), 64'd0);
    step(1'b0);
    check_eq("first_xy", 64'({vif0.DrawX, vif0.DrawY}), 64'd0);
    check_eq("first_blank", 64'(vif0.blank), 64'd1);
    check_eq("first_fs", 64'(vif0.frame_start), 64'd1);
    check_eq("first_fc", 64'(vif0.frame_cnt), 64'd1);

    // One full default line; small DUTs also sweep several frames meanwhile.
    hs_low = 0; bl_hi = 1; ls_cnt = 1; fall_x = -1; hs_first = -1;
    vs_low = 0; fs_prev = -1; fs_period = -1;
    for (int n = 1; n < 800; n++) begin
      step(1'b0);
      if (!vif0.hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(vif0.DrawX);
      end
      if (vif0.blank) bl_hi++;
      else if (fall_x < 0) fall_x = int'(vif0.DrawX);
      if (vif0.line_start) ls_cnt++;
      if (n <= 150 && !vif1.vs) vs_low++;
      if (vif1.frame_start) begin
        if (fs_prev >= 0) fs_period = cyc - fs_prev;
        fs_prev = cyc;
      end
    end
    check_eq("hs_low_cycles", 64'(hs_low), 64'd96);
    check_eq("hs_first_x", 64'(hs_first), 64'd656);
    check_eq("blank_fall_x", 64'(fall_x), 64'd640);
    check_eq("blank_hi_cycles", 64'(bl_hi), 64'd640);
    check_eq("line_start_cnt", 64'(ls_cnt), 64'd1);
    check_eq("small_vs_low", 64'(vs_low), 64'd30);
    check_eq("small_fs_period", 64'(fs_period), 64'd150);
    step(1'b0);
    check_eq("line1_xy", 64'({vif0.DrawX, vif0.DrawY}), 64'({10'd0, 10'd1}));

    // Reset asserted while inside hs.
    found = 0;
    for (int n = 0; n < 900 && found == 0; n++) begin
      step(1'b0);
      if (vif0.DrawX == 10'd700) found = 1;
    end
    check_eq("reach_x700", 64'(found), 64'd1);
    check_eq("pre_rst_hs", 64'(vif0.hs), 64'd0);
    step(1'b1);
    check_eq("mr_hs", 64'(vif0.hs), 64'd1);
    check_eq("mr_hs_d", 64'(vif0.hs_d), 64'd1);
    check_eq("mr_blank_d", 64'(vif0.blank_d), 64'd0);
    step(1'b1);
    step(1'b0);
    check_eq("mr_restart_xy", 64'({vif0.DrawX, vif0.DrawY}), 64'd0);
    check_eq("mr_restart_fc", 64'(vif0.frame_cnt), 64'd1);

    // Frame counter wrap on the small PIPE_DLY=2 DUT.
    repeat (20) step(1'b0);
    force dut1.frame_count = 16'hFFFF;
    #1;
    release dut1.frame_count;
    mfc[1] = 16'hFFFF;
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      step(1'b0);
      if (vif1.frame_start) found = 1;
    end
    check_eq("wrap_found", 64'(found), 64'd1);
    check_eq("wrap_fc", 64'(vif1.frame_cnt), 64'd0);
    repeat (40) step(1'b0);

    finish_up();
  end

endmodule
